updown_count_sched: RTL and testbench

Two-requester scheduler that owns one shared modulo up/down counter. Each requester issues a command (direction, step count) over a valid/ready handshake. A round-robin arbiter grants one command at a time. The FSM steps the counter once per cycle for the requested number of steps, then pulses `done` to the owning requester. It sits between control agents and the counter datapath, so the counter itself never sees conflicting up/down requests.

---
 rtl/updown_count_sched_pkg.sv | 30 +++
 rtl/updown_count_sched_if.sv | 30 +++
 rtl/updown_count_core.sv | 50 +++++
 rtl/updown_count_sched.sv | 144 ++++++++++++++
 tb/tb_updown_count_sched.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/updown_count_sched_pkg.sv
// Shared types and constants for the up/down counter scheduler.
//   state_t      : scheduler FSM states
//   DIR_UP/DOWN  : command direction encoding
//   req_idx_t    : requester index (two requesters)
//   req_onehot() : requester index to per-requester bit vector
package updown_sched_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned REQ_W   = 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [REQ_W-1:0] req_idx_t;

    // Index to one-hot requester mask.
    function automatic logic [NUM_REQ-1:0] req_onehot(input req_idx_t idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/updown_count_sched_if.sv
// Requester-side command handshake bundle for the scheduler.
//   req_valid  : per-requester command valid (bit i = requester i)
//   req_ready  : per-requester accept, at most one bit high
//   req_dir    : per-requester direction, 1 = up, 0 = down
//   req_steps0 : step count of requester 0
//   req_steps1 : step count of requester 1
//   done       : one-cycle completion pulse to the owning requester
interface updown_count_sched_if #(
    parameter int unsigned SW = 8
);
    import updown_sched_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] req_dir;
    logic [SW-1:0]      req_steps0;
    logic [SW-1:0]      req_steps1;
    logic [NUM_REQ-1:0] done;

    modport master (
        output req_valid, req_dir, req_steps0, req_steps1,
        input  req_ready, done
    );

    modport slave (
        input  req_valid, req_dir, req_steps0, req_steps1,
        output req_ready, done
    );

endinterface

// File: rtl/updown_count_core.sv
// Modulo (MAX+1) up/down counter, one step per enabled cycle.
//   clk, reset : clock, synchronous active-low reset
//   en         : take one step this cycle
//   dir        : 1 = up, 0 = down
//   count      : counter value, 0..MAX
//   wrap       : one-cycle pulse alongside a MAX->0 or 0->MAX step
module updown_count_core
    import updown_sched_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         dir,
    output logic [N-1:0] count,
    output logic         wrap
);

    localparam logic [N-1:0] MAX_V = N'(MAX);

    // Counter register with wrap at both ends of the range.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                if (dir == DIR_UP) begin
                    if (count == MAX_V) begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end else begin
                        count <= count + N'(1);
                    end
                end else begin
                    if (count == '0) begin
                        count <= MAX_V;
                        wrap  <= 1'b1;
                    end else begin
                        count <= count - N'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/updown_count_sched.sv
// Two-requester round-robin scheduler owning one shared up/down counter.
//   clk, reset : clock, synchronous active-low reset
//   bus        : command handshake (valid/ready/dir/steps) and done pulses
//   busy       : high while a command is running or completing
//   owner      : current or last granted requester
//   count      : shared counter value
//   wrap       : one-cycle pulse on a counter wrap
module updown_count_sched
    import updown_sched_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned MAX = 255,
    parameter int unsigned SW  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_count_sched_if.slave  bus,
    output logic                 busy,
    output req_idx_t             owner,
    output logic [N-1:0]         count,
    output logic                 wrap
);

    state_t             state_q, state_d;
    logic [SW-1:0]      rem_q, rem_d;
    logic               dir_q, dir_d;
    req_idx_t           owner_q, owner_d;
    req_idx_t           last_owner_q, last_owner_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;

    req_idx_t           grant_c;
    logic               grant_valid_c;
    logic [NUM_REQ-1:0] ready_c;
    logic               accept_c;
    logic [SW-1:0]      sel_steps_c;
    logic               sel_dir_c;
    logic               core_en_c;

    // Round-robin pick: a lone requester wins, a tie goes away from last_owner.
    always_comb begin
        grant_c       = '0;
        grant_valid_c = 1'b0;
        case (bus.req_valid)
            2'b01: begin
                grant_c       = REQ_W'(0);
                grant_valid_c = 1'b1;
            end
            2'b10: begin
                grant_c       = REQ_W'(1);
                grant_valid_c = 1'b1;
            end
            2'b11: begin
                grant_c       = ~last_owner_q;
                grant_valid_c = 1'b1;
            end
            default: begin
                grant_c       = '0;
                grant_valid_c = 1'b0;
            end
        endcase
    end

    // Ready only in IDLE and never while reset is held.
    assign ready_c       = (reset && state_q == IDLE && grant_valid_c) ? req_onehot(grant_c) : '0;
    assign accept_c      = |(bus.req_valid & ready_c);
    assign sel_steps_c   = (grant_c == REQ_W'(1)) ? bus.req_steps1 : bus.req_steps0;
    assign sel_dir_c     = bus.req_dir[grant_c];
    assign core_en_c     = (state_q == RUN);

    // Next-state and register-input logic.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    dir_d   = sel_dir_c;
                    rem_d   = sel_steps_c;
                    owner_d = grant_c;
                    state_d = (sel_steps_c == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rem_d = rem_q - SW'(1);
                if (rem_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // done is registered so it is high exactly for the cycle spent in DONE.
        done_d = (state_d == DONE) ? req_onehot(owner_d) : '0;
        busy_d = (state_d != IDLE);
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            dir_q        <= DIR_DOWN;
            owner_q      <= '0;
            last_owner_q <= REQ_W'(1);
            done_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.done      = done_q;
    assign busy          = busy_q;
    assign owner         = owner_q;

    updown_count_core #(
        .N   (N),
        .MAX (MAX)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (core_en_c),
        .dir   (dir_q),
        .count (count),
        .wrap  (wrap)
    );

endmodule

// File: tb/tb_updown_count_sched.sv
// Directed bench for updown_count_sched with a per-cycle expected-result queue.
module tb_updown_count_sched;
    import updown_sched_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned MAX = 255;
    localparam int unsigned SW  = 8;

    typedef struct {
        logic [N-1:0] count;
        logic         wrap;
        logic [1:0]   done;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         busy;
    logic         owner;
    logic [N-1:0] count;
    logic         wrap;

    int   errors = 0;
    int   checks = 0;
    int   model_count = 0;
    exp_t sb[$];

    updown_count_sched_if #(.SW(SW)) bus ();

    updown_count_sched #(.N(N), .MAX(MAX), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .owner (owner),
        .count (count),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference step of the modulo counter.
    function automatic logic model_step(input logic d);
        logic w;
        w = 1'b0;
        if (d) begin
            if (model_count == int'(MAX)) begin
                model_count = 0;
                w = 1'b1;
            end else begin
                model_count = model_count + 1;
            end
        end else begin
            if (model_count == 0) begin
                model_count = int'(MAX);
                w = 1'b1;
            end else begin
                model_count = model_count - 1;
            end
        end
        return w;
    endfunction

    // One command from requester r; poke raises the other requester's valid during RUN.
    task automatic do_cmd(input int r, input logic d, input int s, input bit poke);
        logic [1:0] oh;
        exp_t       e;
        oh = 2'b01 << r;
        for (int k = 1; k <= s; k++) begin
            e.wrap  = model_step(d);
            e.count = N'(model_count);
            e.done  = (k == s) ? oh : 2'b00;
            sb.push_back(e);
        end
        bus.req_valid = oh;
        bus.req_dir[r] = d;
        if (r == 0) bus.req_steps0 = SW'(s);
        else        bus.req_steps1 = SW'(s);
        #1;
        chk("ready_idle", 32'(bus.req_ready), 32'(oh));
        tick();
        chk("ready_after_accept", 32'(bus.req_ready), 32'(0));
        bus.req_valid = 2'b00;
        chk("owner", 32'(owner), 32'(r));
        chk("busy_accept", 32'(busy), 32'(1));
        chk("done_accept", 32'(bus.done), (s == 0) ? 32'(oh) : 32'(0));
        for (int k = 1; k <= s; k++) begin
            if (poke && k == 1) begin
                bus.req_valid = ~oh;
                #1;
                chk("ready_poke", 32'(bus.req_ready), 32'(0));
            end else if (poke && k == 2) begin
                bus.req_valid = 2'b00;
            end
            tick();
            e = sb.pop_front();
            chk("count_step", 32'(count), 32'(e.count));
            chk("wrap_step", 32'(wrap), 32'(e.wrap));
            chk("done_step", 32'(bus.done), 32'(e.done));
            chk("busy_step", 32'(busy), 32'(1));
            chk("ready_step", 32'(bus.req_ready), 32'(0));
        end
        tick();
        chk("done_clear", 32'(bus.done), 32'(0));
        chk("busy_clear", 32'(busy), 32'(0));
        chk("count_hold", 32'(count), 32'(model_count));
        chk("wrap_clear", 32'(wrap), 32'(0));
    endtask

    initial begin
        logic [1:0] oh;
        exp_t       e;

        // Reset state, with both requesters asking.
        reset          = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_dir    = 2'b00;
        bus.req_steps0 = '0;
        bus.req_steps1 = '0;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_wrap", 32'(wrap), 32'(0));
        chk("rst_owner", 32'(owner), 32'(0));
        bus.req_valid = 2'b00;
        reset = 1'b1;

        // Basic up run, zero-step command, back-to-back down, ignored poke.
        do_cmd(0, 1'b1, 3, 1'b0);
        do_cmd(1, 1'b1, 0, 1'b0);
        do_cmd(1, 1'b0, 1, 1'b0);
        do_cmd(1, 1'b1, 4, 1'b1);

        // Reset in the middle of a run at count 5.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_count = 0;
        bus.req_valid  = 2'b01;
        bus.req_dir    = 2'b11;
        bus.req_steps0 = SW'(10);
        tick();
        bus.req_valid = 2'b00;
        repeat (5) tick();
        chk("mid_count", 32'(count), 32'(5));
        chk("mid_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_steps0 = SW'(1);
        bus.req_steps1 = SW'(1);
        tick();
        chk("mid_rst_count", 32'(count), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(bus.done), 32'(0));
        chk("mid_rst_ready", 32'(bus.req_ready), 32'(0));
        model_count = 0;

        // Continuous tie: grants alternate starting with requester 0.
        reset = 1'b1;
        for (int g = 0; g < 4; g++) begin
            oh = 2'b01 << (g % 2);
            e.wrap  = model_step(1'b1);
            e.count = N'(model_count);
            e.done  = oh;
            sb.push_back(e);
            #1;
            chk("rr_ready", 32'(bus.req_ready), 32'(oh));
            tick();
            chk("rr_owner", 32'(owner), 32'(g % 2));
            chk("rr_done_run", 32'(bus.done), 32'(0));
            tick();
            e = sb.pop_front();
            chk("rr_count", 32'(count), 32'(e.count));
            chk("rr_done", 32'(bus.done), 32'(e.done));
            tick();
            chk("rr_done_clear", 32'(bus.done), 32'(0));
            chk("rr_busy_clear", 32'(busy), 32'(0));
        end
        bus.req_valid = 2'b00;

        // Wrap in both directions.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_count = 0;
        do_cmd(0, 1'b0, 2, 1'b0);
        do_cmd(0, 1'b1, 3, 1'b0);
        do_cmd(1, 1'b0, 2, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
